// File: rtl/bsdeser.sv
// bsdeser: framed LSB-first serial-to-parallel receiver with a one-entry
// valid/ready output register and sticky overflow/resync error flags.
module bsdeser #(
    parameter int WLEN = 10,
    parameter int CW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sin,
    input  logic            isync,
    output logic [WLEN-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            ovf_err,
    output logic            sync_err,
    input  logic            clr_err
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WLEN-1:0] sh_q, sh_d, data_q, data_d, word;
    logic            valid_q, valid_d, ovf_q, ovf_d, serr_q, serr_d;
    logic            done, resync, ovf_set;
    always_comb begin
        word    = {sin, sh_q[WLEN-1:1]};
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        done    = 1'b0;
        resync  = 1'b0;
        if (state_q == IDLE) begin
            if (isync) begin
                sh_d    = word;
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
        end else begin
            sh_d = word;
            // an isync on any bit of a running frame, including the last, restarts it
            if (isync) begin
                resync = 1'b1;
                cnt_d  = CW'(1);
            end else if (cnt_q == CW'(WLEN-1)) begin
                done    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_set = done && valid_q && !out_ready;
        if (done && !ovf_set) begin
            data_d  = word;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        ovf_d  = ovf_set | (ovf_q & ~clr_err);
        serr_d = resync | (serr_q & ~clr_err);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
        end
    end
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == SHIFT);
    assign ovf_err   = ovf_q;
    assign sync_err  = serr_q;
endmodule

// File: tb/tb_bsdeser.sv
// tb_bsdeser: per-cycle vector table plus reset and bounded-wait checks for bsdeser
module tb_bsdeser;
  logic clk = 1'b0, reset = 1'b0, sin = 1'b0, isync = 1'b0;
  logic out_ready = 1'b0, clr_err = 1'b0;
  logic [9:0] out_data;
  logic out_valid, busy, ovf_err, sync_err;
  int n_chk = 0, n_fail = 0;
  bsdeser #(.WLEN(10), .CW(4)) dut (
    .clk(clk), .reset(reset), .sin(sin), .isync(isync),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .ovf_err(ovf_err), .sync_err(sync_err), .clr_err(clr_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, s, sy, rdy, clr;
    logic ev, eb, eo, es;
    logic [9:0] ed;
    string tag;
  } vec_t;
  vec_t vq[$];
  task automatic add(input string tag, input logic rst, s, sy, rdy, clr,
                     input logic ev, input logic [9:0] ed, input logic eb, eo, es);
    vec_t v;
    v.tag = tag; v.rst = rst; v.s = s; v.sy = sy; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo; v.es = es;
    vq.push_back(v);
  endtask
  task automatic frame(input string tag, input logic [9:0] w, input logic rdy_mid, rdy_end,
                       input logic ev_mid, input logic [9:0] ed_mid,
                       input logic ev_end, input logic [9:0] ed_end,
                       input logic eo_mid, eo_end, es);
    for (int i = 0; i < 10; i++)
      if (i < 9) add(tag, 1, w[i], i == 0, rdy_mid, 0, ev_mid, ed_mid, 1, eo_mid, es);
      else add(tag, 1, w[i], 0, rdy_end, 0, ev_end, ed_end, 0, eo_end, es);
  endtask
  task automatic partial(input string tag, input int n, input logic rdy,
                         input logic ev, input logic [9:0] ed, input logic es);
    for (int i = 0; i < n; i++) add(tag, 1, i[0], i == 0, rdy, 0, ev, ed, 1, 0, es);
  endtask
  initial begin
    int w;
    logic [9:0] fw;
    add("reset0", 0, 1, 1, 1, 0, 0, 10'h000, 0, 0, 0);
    add("reset1", 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    frame("single", 10'h2A3, 1, 1, 0, 10'h000, 1, 10'h2A3, 0, 0, 0);
    add("single_take", 1, 0, 0, 1, 0, 0, 10'h2A3, 0, 0, 0);
    frame("b2b_a", 10'h155, 1, 1, 0, 10'h2A3, 1, 10'h155, 0, 0, 0);
    frame("b2b_b", 10'h3FF, 1, 1, 0, 10'h155, 1, 10'h3FF, 0, 0, 0);
    add("b2b_take", 1, 0, 0, 1, 0, 0, 10'h3FF, 0, 0, 0);
    frame("bp_a", 10'h001, 0, 0, 0, 10'h3FF, 1, 10'h001, 0, 0, 0);
    frame("bp_b", 10'h200, 0, 0, 1, 10'h001, 1, 10'h001, 0, 1, 0);
    add("bp_hold", 1, 1, 0, 0, 0, 1, 10'h001, 0, 1, 0);
    add("bp_take", 1, 0, 0, 1, 0, 0, 10'h001, 0, 1, 0);
    add("bp_clr", 1, 0, 0, 0, 1, 0, 10'h001, 0, 0, 0);
    partial("rs_abort", 4, 1, 0, 10'h001, 0);
    frame("rs_frame", 10'h0F0, 1, 1, 0, 10'h001, 1, 10'h0F0, 0, 0, 1);
    add("rs_take", 1, 0, 0, 1, 0, 0, 10'h0F0, 0, 0, 1);
    add("rs_clr", 1, 0, 0, 1, 1, 0, 10'h0F0, 0, 0, 0);
    partial("rst_part", 5, 1, 0, 10'h0F0, 0);
    add("rst_mid", 0, 1, 0, 1, 0, 0, 10'h000, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("rst_nosync", 1, 1, 0, 1, 0, 0, 10'h000, 0, 0, 0);
    frame("rst_frame", 10'h123, 1, 1, 0, 10'h000, 1, 10'h123, 0, 0, 0);
    add("rst_take", 1, 0, 0, 1, 0, 0, 10'h123, 0, 0, 0);
    frame("sim_hold", 10'h0AA, 0, 0, 0, 10'h123, 1, 10'h0AA, 0, 0, 0);
    frame("sim_swap", 10'h055, 0, 1, 1, 10'h0AA, 1, 10'h055, 0, 0, 0);
    partial("last_abort", 9, 1, 0, 10'h055, 0);
    frame("last_frame", 10'h3C3, 1, 1, 0, 10'h055, 1, 10'h3C3, 0, 0, 1);
    add("last_take", 1, 0, 0, 1, 1, 0, 10'h3C3, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      reset = 1'b0; sin = 1'b1; isync = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({out_valid, out_data, busy, ovf_err, sync_err} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h busy=%b ovf=%b serr=%b",
               out_valid, out_data, busy, ovf_err, sync_err);
    end
    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      reset = vq[k].rst; sin = vq[k].s; isync = vq[k].sy;
      out_ready = vq[k].rdy; clr_err = vq[k].clr;
      @(posedge clk);
      #1;
      n_chk++;
      if ({out_valid, out_data, busy, ovf_err, sync_err} !==
          {vq[k].ev, vq[k].ed, vq[k].eb, vq[k].eo, vq[k].es}) begin
        n_fail++;
        $display("FAIL %s vec %0d: got valid=%b data=%h busy=%b ovf=%b serr=%b, want valid=%b data=%h busy=%b ovf=%b serr=%b",
                 vq[k].tag, k, out_valid, out_data, busy, ovf_err, sync_err,
                 vq[k].ev, vq[k].ed, vq[k].eb, vq[k].eo, vq[k].es);
      end
    end
    fw = 10'h1B6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = 1'b1; sin = fw[i]; isync = (i == 0); out_ready = 1'b0; clr_err = 1'b0;
    end
    @(negedge clk);
    sin = 1'b0; isync = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_chk++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL wait_valid: out_valid not seen within 20 cycles");
    end else if (out_data !== fw) begin
      n_fail++;
      $display("FAIL wait_data: got %h want %h", out_data, fw);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
